checker_ctlif: RTL and testbench
================================

Name: checker_ctlif

Overview:
- CSR-mapped control interface of the checker core.
- Software programs a 64-bit target address and a mode, then starts a run.
- The block drives the mode engine (mode_*), captures its 64-bit result, and latches completion, error and user-IRQ events into a write-1-to-clear status register.
- The CPU interrupt line is the OR of pending events, gated by an enable bit.

Parameters:
- csr_addr, 4'h0, CSR bank select compared against csr_a[13:10].

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  reset, asynchronous, active-high
- csr_a  in  14  CSR address; [13:10] bank, [2:0] register index
- csr_we  in  1  CSR write strobe
- csr_di  in  32  CSR write data
- csr_do  out  32  CSR read data, registered
- irq  out  1  interrupt to CPU, level
- mode_mode  out  2  selected mode (CTRL[2:1])
- mode_start  out  1  run request, level, held while running
- mode_addr  out  64  target address {ADDRESS_HIGH, ADDRESS_LOW}
- mode_end  in  1  one-cycle pulse: run finished, mode_data valid
- mode_data  in  64  result from the mode engine
- mode_irq  in  1  user interrupt request from the mode engine, level
- mode_ack  out  1  one-cycle acknowledge of a software-cleared user IRQ
- mode_error  in  1  one-cycle pulse: run aborted on error

Behaviour:
- Clock and reset: one clock, sys_clk. sys_rst is asynchronous and active-high. On reset all registers and outputs are 0: csr_do, irq, mode_mode, mode_start, mode_addr, mode_ack, events, irq_en.
- Register select: sel = (csr_a[13:10] == csr_addr).
- Register map (csr_a[2:0]):
  - 0 CTRL: [0] start, [2:1] mode, [3] irq_en, rest read 0.
  - 1 STAT: [0] event_end, [1] event_user_irq, [2] event_error; write 1 to clear.
  - 2 ADDRESS_LOW.
  - 3 ADDRESS_HIGH.
  - 4 DATA_LOW: read-only, mode_data[31:0] captured at end.
  - 5 DATA_HIGH: read-only, mode_data[63:32].
  - 6–7 read 0.
- Reads: csr_do <= selected register on each clock when sel, else 0. One-cycle latency. A read issued in the same cycle as a write returns the old value.
- CTRL write: updates start, mode and irq_en at once.
  - Writing start=1 while stopped begins a run.
  - Writing start=0 aborts a run with no event.
  - Mode writes are accepted at any time.
- ADDRESS writes are ignored while mode_start=1, so mode_addr stays stable during a run.
- mode_start equals CTRL[0]. It clears on the cycle after mode_end or mode_error.
  - mode_end: sets event_end and captures mode_data.
  - mode_error: sets event_error.
  - If a CPU write of start=1 coincides with mode_end or mode_error, the hardware clear wins.
- event_user_irq: set on the rising edge of mode_irq, using a registered copy of mode_irq.
- Software write of 1 to STAT[1] clears event_user_irq and pulses mode_ack high for exactly one cycle.
- Set-vs-clear collision: if a hardware set and a software clear of the same event coincide, the set wins.
- irq <= irq_en & (event_end | event_user_irq | event_error). Registered, so it rises one cycle after the event bit.
- Events are not cleared by start; only software W1C or reset clears them.
- Reset mid-run: everything returns to 0 and mode_start drops asynchronously.

Decomposition:
- Shared package/header checker.vh holds:
  - CSR indices CHECKER_CSR_CTRL, _STAT, _ADDRESS_LOW, _ADDRESS_HIGH, _DATA_LOW, _DATA_HIGH.
  - CTRL bit positions.
  - STAT masks CHECKER_STAT_EVENT_END, _USER_IRQ, _ERROR.
  - Mode encodings, including CHECKER_MODE_DUMMY = 2'd0.
- No sub-module; a single flat block is natural.

Test Plan:
- Address registers: write ADDRESS_LOW=0xaaaaaaaa and ADDRESS_HIGH=0xbbbbbbbb, then read each. Required: csr_do returns each value one cycle after the read, and mode_addr=0xbbbbbbbbaaaaaaaa.
- Start and end: write CTRL=0x9 (dummy mode, irq_en, start). Required: mode_start=1 and reading CTRL returns 0x9. Then pulse mode_end with mode_data=0x1122334455667788. Required:
  - mode_start=0, STAT=0x1, irq=1.
  - DATA_LOW reads 0x55667788, DATA_HIGH reads 0x11223344.
  - Writing STAT=0x1 drops irq to 0.
- Software abort: write CTRL=0x9, then CTRL=0x8. Required: mode_start falls, STAT stays 0, irq stays 0, CTRL reads 0x8.
- Reset mid-run: with a run active, assert sys_rst. Required: mode_start, mode_addr and irq go to 0 immediately, and CTRL reads 0 after release.
- User IRQ: start a run, then raise mode_irq. Required: STAT[1]=1 and irq=1. Then write STAT=0x2. Required: a one-cycle mode_ack pulse, STAT[1]=0, and irq=0 with mode_irq held low.
- Error and guards:
  - With a run active, pulse mode_error. Required: mode_start=0 and STAT=0x4.
  - Write ADDRESS_LOW during a run. Required: ignored.
  - Run with irq_en=0 and let it end. Required: irq stays 0 while STAT is non-zero.

Source files
------------

// File: rtl/checker_pkg.sv
// Shared constants for the checker control interface: CSR indices, CTRL bit
// positions, STAT event masks and mode encodings.
package checker_pkg;

  localparam logic [2:0] CHECKER_CSR_CTRL         = 3'd0;
  localparam logic [2:0] CHECKER_CSR_STAT         = 3'd1;
  localparam logic [2:0] CHECKER_CSR_ADDRESS_LOW  = 3'd2;
  localparam logic [2:0] CHECKER_CSR_ADDRESS_HIGH = 3'd3;
  localparam logic [2:0] CHECKER_CSR_DATA_LOW     = 3'd4;
  localparam logic [2:0] CHECKER_CSR_DATA_HIGH    = 3'd5;

  localparam int unsigned CHECKER_CTRL_START  = 0;
  localparam int unsigned CHECKER_CTRL_MODE_L = 1;
  localparam int unsigned CHECKER_CTRL_MODE_H = 2;
  localparam int unsigned CHECKER_CTRL_IRQ_EN = 3;

  localparam logic [2:0] CHECKER_STAT_EVENT_END = 3'b001;
  localparam logic [2:0] CHECKER_STAT_USER_IRQ  = 3'b010;
  localparam logic [2:0] CHECKER_STAT_ERROR     = 3'b100;

  localparam logic [1:0] CHECKER_MODE_DUMMY   = 2'd0;
  localparam logic [1:0] CHECKER_MODE_SIMPLE  = 2'd1;
  localparam logic [1:0] CHECKER_MODE_TRAFFIC = 2'd2;
  localparam logic [1:0] CHECKER_MODE_USER    = 2'd3;

  function automatic logic [31:0] ctrl_word(logic irq_en, logic [1:0] mode, logic start);
    return {28'b0, irq_en, mode, start};
  endfunction

endpackage

// File: rtl/checker_ctlif.sv
// CSR control interface of the checker core: run control, 64-bit target address,
// result capture and W1C event status with a gated level interrupt.
module checker_ctlif
  import checker_pkg::*;
#(
  parameter logic [3:0] csr_addr = 4'h0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq,
  output logic [1:0]  mode_mode,
  output logic        mode_start,
  output logic [63:0] mode_addr,
  input  logic        mode_end,
  input  logic [63:0] mode_data,
  input  logic        mode_irq,
  output logic        mode_ack,
  input  logic        mode_error
);

  logic        sel, wr;
  logic [2:0]  idx;
  logic        ctrl_wr, stat_wr;
  logic        unused_addr;

  logic        start_q, start_d;
  logic [1:0]  mode_q, mode_d;
  logic        irq_en_q, irq_en_d;
  logic [31:0] addr_lo_q, addr_lo_d;
  logic [31:0] addr_hi_q, addr_hi_d;
  logic [63:0] data_q, data_d;
  logic [2:0]  ev_q, ev_d, ev_set, ev_clr;
  logic        mode_irq_q;
  logic        ack_q, ack_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata, csr_do_q, csr_do_d;

  assign sel         = (csr_a[13:10] == csr_addr);
  assign wr          = sel & csr_we;
  assign idx         = csr_a[2:0];
  assign ctrl_wr     = wr && (idx == CHECKER_CSR_CTRL);
  assign stat_wr     = wr && (idx == CHECKER_CSR_STAT);
  assign unused_addr = ^csr_a[9:3];

  always_comb begin
    start_d   = start_q;
    mode_d    = mode_q;
    irq_en_d  = irq_en_q;
    addr_lo_d = addr_lo_q;
    addr_hi_d = addr_hi_q;
    data_d    = data_q;

    if (ctrl_wr) begin
      start_d  = csr_di[CHECKER_CTRL_START];
      mode_d   = csr_di[CHECKER_CTRL_MODE_H:CHECKER_CTRL_MODE_L];
      irq_en_d = csr_di[CHECKER_CTRL_IRQ_EN];
    end
    // Completion/abort from the engine overrides a coincident software start.
    if (mode_end || mode_error) begin
      start_d = 1'b0;
    end

    // Address is frozen while a run is in flight.
    if (!start_q && wr && (idx == CHECKER_CSR_ADDRESS_LOW)) begin
      addr_lo_d = csr_di;
    end
    if (!start_q && wr && (idx == CHECKER_CSR_ADDRESS_HIGH)) begin
      addr_hi_d = csr_di;
    end

    if (mode_end) begin
      data_d = mode_data;
    end

    ev_set = {mode_error, mode_irq & ~mode_irq_q, mode_end};
    ev_clr = stat_wr ? csr_di[2:0] : 3'b000;
    // Set after clear, so a hardware event beats a simultaneous W1C.
    ev_d   = (ev_q & ~ev_clr) | ev_set;

    ack_d  = stat_wr & csr_di[1];
    irq_d  = irq_en_q & (|ev_q);

    case (idx)
      CHECKER_CSR_CTRL:         rdata = ctrl_word(irq_en_q, mode_q, start_q);
      CHECKER_CSR_STAT:         rdata = {29'b0, ev_q};
      CHECKER_CSR_ADDRESS_LOW:  rdata = addr_lo_q;
      CHECKER_CSR_ADDRESS_HIGH: rdata = addr_hi_q;
      CHECKER_CSR_DATA_LOW:     rdata = data_q[31:0];
      CHECKER_CSR_DATA_HIGH:    rdata = data_q[63:32];
      default:                  rdata = 32'b0;
    endcase
    csr_do_d = sel ? rdata : 32'b0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      start_q    <= 1'b0;
      mode_q     <= 2'b0;
      irq_en_q   <= 1'b0;
      addr_lo_q  <= 32'b0;
      addr_hi_q  <= 32'b0;
      data_q     <= 64'b0;
      ev_q       <= 3'b0;
      mode_irq_q <= 1'b0;
      ack_q      <= 1'b0;
      irq_q      <= 1'b0;
      csr_do_q   <= 32'b0;
    end else begin
      start_q    <= start_d;
      mode_q     <= mode_d;
      irq_en_q   <= irq_en_d;
      addr_lo_q  <= addr_lo_d;
      addr_hi_q  <= addr_hi_d;
      data_q     <= data_d;
      ev_q       <= ev_d;
      mode_irq_q <= mode_irq;
      ack_q      <= ack_d;
      irq_q      <= irq_d;
      csr_do_q   <= csr_do_d;
    end
  end

  assign csr_do     = csr_do_q;
  assign irq        = irq_q;
  assign mode_mode  = mode_q;
  assign mode_start = start_q;
  assign mode_addr  = {addr_hi_q, addr_lo_q};
  assign mode_ack   = ack_q;

endmodule

// File: tb/tb_checker_ctlif.sv
// Randomised and directed bench for checker_ctlif: CSR read data goes through an
// expected-value queue checked by a monitor; pin outputs are checked against a model.
module tb_checker_ctlif;

  localparam logic [3:0] Bank  = 4'h0;
  localparam logic [3:0] Other = 4'h5;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [13:0] csr_a = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = '0;
  logic [31:0] csr_do;
  logic        irq;
  logic [1:0]  mode_mode;
  logic        mode_start;
  logic [63:0] mode_addr;
  logic        mode_end = 1'b0;
  logic [63:0] mode_data = '0;
  logic        mode_irq = 1'b0;
  logic        mode_ack;
  logic        mode_error = 1'b0;

  checker_ctlif #(.csr_addr(Bank)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .csr_a      (csr_a),
    .csr_we     (csr_we),
    .csr_di     (csr_di),
    .csr_do     (csr_do),
    .irq        (irq),
    .mode_mode  (mode_mode),
    .mode_start (mode_start),
    .mode_addr  (mode_addr),
    .mode_end   (mode_end),
    .mode_data  (mode_data),
    .mode_irq   (mode_irq),
    .mode_ack   (mode_ack),
    .mode_error (mode_error)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model of the software-visible state after each clock.
  logic        m_start, m_irq_en, m_mirq_prev, m_ack, m_irq;
  logic [1:0]  m_mode;
  logic [63:0] m_addr, m_data;
  logic [2:0]  m_ev;
  logic        uirq_lvl = 1'b0;

  logic [31:0] exp_q[$];
  logic        pushed = 1'b0;
  logic        rd_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) rd_v <= 1'b0;
    else         rd_v <= pushed;
  end

  always @(negedge sys_clk) begin
    if (rd_v) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL csr_do_underflow: got %h with no expected value", csr_do);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (csr_do !== e) begin
          miscompares++;
          $display("FAIL csr_do: got %h, expected %h at %0t", csr_do, e, $time);
        end
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [2:0] idx);
    case (idx)
      3'd0:    return {28'b0, m_irq_en, m_mode, m_start};
      3'd1:    return {29'b0, m_ev};
      3'd2:    return m_addr[31:0];
      3'd3:    return m_addr[63:32];
      3'd4:    return m_data[31:0];
      3'd5:    return m_data[63:32];
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_start = 0; m_irq_en = 0; m_mirq_prev = 0; m_ack = 0; m_irq = 0;
    m_mode = 0; m_addr = 0; m_data = 0; m_ev = 0;
  endtask

  task automatic cycle(input logic [3:0] bank, input logic [2:0] idx, input logic we,
                       input logic [31:0] di, input logic e, input logic [63:0] d,
                       input logic ui, input logic er);
    logic wr, irq_n;
    logic [2:0] set, clr;
    @(negedge sys_clk);
    csr_a = {bank, 7'h0, idx}; csr_we = we; csr_di = di;
    mode_end = e; mode_data = d; mode_irq = ui; mode_error = er;
    exp_q.push_back((bank == Bank) ? model_read(idx) : 32'b0);
    pushed = 1'b1;

    wr    = (bank == Bank) && we;
    irq_n = m_irq_en && (m_ev != 3'b0);
    m_ack = wr && idx == 3'd1 && di[1];
    set   = {er, ui && !m_mirq_prev, e};
    clr   = (wr && idx == 3'd1) ? di[2:0] : 3'b0;
    m_ev  = (m_ev & ~clr) | set;
    if (wr && !m_start && idx == 3'd2) m_addr[31:0]  = di;
    if (wr && !m_start && idx == 3'd3) m_addr[63:32] = di;
    if (wr && idx == 3'd0) begin
      m_start = di[0]; m_mode = di[2:1]; m_irq_en = di[3];
    end
    if (e || er) m_start = 1'b0;
    if (e) m_data = d;
    m_mirq_prev = ui;
    m_irq = irq_n;

    @(posedge sys_clk);
    #1;
    check("mode_start", mode_start, m_start);
    check("mode_mode", mode_mode, m_mode);
    check("mode_addr", mode_addr, m_addr);
    check("irq", irq, m_irq);
    check("mode_ack", mode_ack, m_ack);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] di);
    cycle(Bank, idx, 1'b1, di, 1'b0, 64'b0, uirq_lvl, 1'b0);
  endtask

  task automatic rd(input logic [2:0] idx);
    cycle(Bank, idx, 1'b0, 32'b0, 1'b0, 64'b0, uirq_lvl, 1'b0);
  endtask

  task automatic idle();
    cycle(Other, 3'd0, 1'b0, 32'b0, 1'b0, 64'b0, uirq_lvl, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    pushed = 1'b0;
    csr_we = 0; mode_end = 0; mode_error = 0; mode_irq = 0; uirq_lvl = 0;
    #2 sys_rst = 1'b1;
    #1;
    check("rst_mode_start", mode_start, 1'b0);
    check("rst_mode_addr", mode_addr, 64'b0);
    check("rst_irq", irq, 1'b0);
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check("init_csr_do", csr_do, 32'b0);
    check("init_mode_start", mode_start, 1'b0);
    check("init_irq", irq, 1'b0);
    check("init_mode_addr", mode_addr, 64'b0);
    check("init_mode_ack", mode_ack, 1'b0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Address registers.
    wr(3'd2, 32'haaaaaaaa);
    wr(3'd3, 32'hbbbbbbbb);
    rd(3'd2);
    rd(3'd3);
    check("addr_const", mode_addr, 64'hbbbbbbbbaaaaaaaa);

    // Start and end.
    wr(3'd0, 32'h9);
    check("start_const", mode_start, 1'b1);
    rd(3'd0);
    cycle(Bank, 3'd0, 1'b0, 32'b0, 1'b1, 64'h1122334455667788, 1'b0, 1'b0);
    check("end_clears_start", mode_start, 1'b0);
    rd(3'd1);
    check("end_irq_const", irq, 1'b1);
    rd(3'd4);
    rd(3'd5);
    wr(3'd1, 32'h1);
    idle();
    check("w1c_irq_const", irq, 1'b0);

    // Software abort.
    wr(3'd0, 32'h9);
    wr(3'd0, 32'h8);
    check("abort_const", mode_start, 1'b0);
    rd(3'd1);
    rd(3'd0);
    idle();

    // Reset mid-run.
    wr(3'd2, 32'h12345678);
    wr(3'd0, 32'h9);
    do_reset();
    rd(3'd0);
    idle();

    // User IRQ.
    wr(3'd0, 32'h9);
    uirq_lvl = 1'b1;
    idle();
    idle();
    check("uirq_irq_const", irq, 1'b1);
    rd(3'd1);
    uirq_lvl = 1'b0;
    idle();
    wr(3'd1, 32'h2);
    check("ack_pulse_const", mode_ack, 1'b1);
    idle();
    check("ack_single_const", mode_ack, 1'b0);
    rd(3'd1);
    check("uirq_clr_irq_const", irq, 1'b0);

    // Error while running.
    cycle(Bank, 3'd1, 1'b0, 32'b0, 1'b0, 64'b0, 1'b0, 1'b1);
    check("err_clears_start", mode_start, 1'b0);
    rd(3'd1);
    wr(3'd1, 32'h7);

    // Address guard.
    wr(3'd2, 32'h11111111);
    wr(3'd0, 32'h9);
    wr(3'd2, 32'hdeadbeef);
    check("addr_guard_const", mode_addr[31:0], 32'h11111111);
    rd(3'd2);

    // Run with irq_en=0.
    wr(3'd0, 32'h1);
    cycle(Bank, 3'd0, 1'b0, 32'b0, 1'b1, 64'hcafef00d0badbeef, 1'b0, 1'b0);
    idle();
    idle();
    check("no_irq_en_const", irq, 1'b0);
    rd(3'd1);
    wr(3'd1, 32'h7);

    // Collisions: end vs start write, and set vs W1C.
    wr(3'd0, 32'h9);
    cycle(Bank, 3'd0, 1'b1, 32'h9, 1'b1, 64'h5, 1'b0, 1'b0);
    check("collide_start_const", mode_start, 1'b0);
    cycle(Bank, 3'd1, 1'b1, 32'h1, 1'b1, 64'h6, 1'b0, 1'b0);
    rd(3'd1);
    wr(3'd1, 32'h7);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      logic [3:0]  b;
      logic [2:0]  ix;
      logic        we, e, er;
      logic [31:0] di;
      b  = ($urandom_range(0, 7) == 0) ? Other : Bank;
      ix = 3'($urandom_range(0, 7));
      we = ($urandom_range(0, 2) == 0);
      di = $urandom;
      if (ix == 3'd0 && $urandom_range(0, 1) == 1) di = {28'b0, di[3:1], 1'b1};
      e  = m_start && ($urandom_range(0, 7) == 0);
      er = m_start && !e && ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) uirq_lvl = ~uirq_lvl;
      cycle(b, ix, we, di, e, {$urandom, $urandom}, uirq_lvl, er);
    end

    idle();
    @(negedge sys_clk);
    pushed = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
